// File: rtl/henon_draw_sequencer_pkg.sv
// Shared definitions for the Henon-map tarot draw sequencer.
// Holds deck geometry, the bit positions of the card fields inside the
// Q1.31 map x value, default timing limits and the sequencer state enum.
package henon_draw_sequencer_pkg;

    localparam int DECK_SIZE      = 78;
    localparam int MAX_CARDS      = 10;
    localparam int WARMUP_DEF     = 16;
    localparam int TIMEOUT_DEF    = 16;
    localparam int MAX_REJECT_DEF = 255;

    // Card fields carved out of map x: idx = x[22:16], rev = x[8]
    localparam int IDX_W   = 7;
    localparam int IDX_LSB = 16;
    localparam int REV_BIT = 8;
    localparam int NUM_W   = 4;

    typedef logic signed [31:0] q31_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FIRE,
        S_WAIT,
        S_EVAL,
        S_FINISH
    } state_e;

endpackage

// File: rtl/henon_draw_sequencer_draw_mask.sv
// Used-card register: one bit per deck position.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   clear             zero the whole mask (has priority over set)
//   set, set_idx      mark card set_idx as drawn
//   query_idx, hit    hit=1 when query_idx is already drawn
// Indices outside the deck never set a bit and never report a hit.
module henon_draw_sequencer_draw_mask
    import henon_draw_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             set,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [IDX_W-1:0] query_idx,
    output logic             hit
);

    localparam logic [IDX_W-1:0] DECK_LIM = IDX_W'(DECK_SIZE);

    logic [DECK_SIZE-1:0] mask_q, mask_d;

    always_comb begin
        mask_d = mask_q;
        if (clear) begin
            mask_d = '0;
        end else if (set && (set_idx < DECK_LIM)) begin
            mask_d[set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign hit = (query_idx < DECK_LIM) ? mask_q[query_idx] : 1'b0;

endmodule

// File: rtl/henon_draw_sequencer.sv
// Tarot draw sequencer driving one Q1.31 Henon-map iterator.
// On a request it seeds the map, discards WARMUP results, then keeps
// iterating (feeding each result back as the next input) and turns map x
// into card picks, rejecting out-of-deck and already-drawn indices.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   req, num_cards                   draw request (IDLE only) and card count
//   seed_x/seed_y, coef_a/coef_b     map operands captured on request
//   perturb                          entropy, captured with every map_start
//   map_start, map_x/y/a/b/perturb   map request side
//   map_x_out, map_y_out, map_done   map result side
//   busy, card_valid/idx/rev, draw_done   draw status and card stream
//   err_timeout, err_stall           sticky error flags
module henon_draw_sequencer
    import henon_draw_sequencer_pkg::*;
#(
    parameter int WARMUP     = WARMUP_DEF,
    parameter int TIMEOUT    = TIMEOUT_DEF,   // must be >= 2
    parameter int MAX_REJECT = MAX_REJECT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [NUM_W-1:0] num_cards,
    input  logic [31:0]      seed_x,
    input  logic [31:0]      seed_y,
    input  logic [31:0]      coef_a,
    input  logic [31:0]      coef_b,
    input  logic [31:0]      perturb,
    output logic             map_start,
    output logic [31:0]      map_x,
    output logic [31:0]      map_y,
    output logic [31:0]      map_a,
    output logic [31:0]      map_b,
    output logic [31:0]      map_perturb,
    input  logic [31:0]      map_x_out,
    input  logic [31:0]      map_y_out,
    input  logic             map_done,
    output logic             busy,
    output logic             card_valid,
    output logic [IDX_W-1:0] card_idx,
    output logic             card_rev,
    output logic             draw_done,
    output logic             err_timeout,
    output logic             err_stall
);

    localparam int WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam int REJ_W  = $clog2(MAX_REJECT + 1);
    localparam logic [IDX_W-1:0] DECK_LIM = IDX_W'(DECK_SIZE);

    state_e           state_q, state_d;
    q31_t             map_x_q, map_x_d, map_y_q, map_y_d;
    q31_t             map_a_q, map_a_d, map_b_q, map_b_d;
    q31_t             map_perturb_q, map_perturb_d;
    logic [WARM_W-1:0] warm_q, warm_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [REJ_W-1:0] rej_q, rej_d;
    logic [NUM_W-1:0] num_q, num_d, drawn_q, drawn_d;
    logic             err_timeout_q, err_timeout_d, err_stall_q, err_stall_d;

    logic             mask_clr, mask_set, mask_hit;
    logic [IDX_W-1:0] cand_idx;
    logic             cand_rev;

    assign cand_idx = map_x_q[IDX_LSB +: IDX_W];
    assign cand_rev = map_x_q[REV_BIT];

    henon_draw_sequencer_draw_mask u_draw_mask (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (mask_clr),
        .set       (mask_set),
        .set_idx   (cand_idx),
        .query_idx (cand_idx),
        .hit       (mask_hit)
    );

    always_comb begin
        state_d       = state_q;
        map_x_d       = map_x_q;
        map_y_d       = map_y_q;
        map_a_d       = map_a_q;
        map_b_d       = map_b_q;
        map_perturb_d = map_perturb_q;
        warm_d        = warm_q;
        tmo_d         = tmo_q;
        rej_d         = rej_q;
        num_d         = num_q;
        drawn_d       = drawn_q;
        err_timeout_d = err_timeout_q;
        err_stall_d   = err_stall_q;
        mask_clr      = 1'b0;
        mask_set      = 1'b0;
        card_valid    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    map_x_d       = seed_x;
                    map_y_d       = seed_y;
                    map_a_d       = coef_a;
                    map_b_d       = coef_b;
                    num_d         = (num_cards > NUM_W'(MAX_CARDS)) ? NUM_W'(MAX_CARDS)
                                                                    : num_cards;
                    warm_d        = WARM_W'(WARMUP);
                    drawn_d       = '0;
                    rej_d         = '0;
                    err_timeout_d = 1'b0;
                    err_stall_d   = 1'b0;
                    mask_clr      = 1'b1;
                    state_d       = S_FIRE;
                end
            end

            S_FIRE: begin
                map_perturb_d = perturb;
                tmo_d         = '0;
                state_d       = S_WAIT;
            end

            S_WAIT: begin
                // tmo_q counts WAIT cycles; the last cycle that still
                // accepts map_done is TIMEOUT-1 cycles after the pulse, so
                // the flag rises exactly TIMEOUT cycles after it.
                if (map_done) begin
                    map_x_d = map_x_out;
                    map_y_d = map_y_out;
                    state_d = S_EVAL;
                end else if (tmo_q == TMO_W'(TIMEOUT - 2)) begin
                    err_timeout_d = 1'b1;
                    state_d       = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            S_EVAL: begin
                if (warm_q != '0) begin
                    warm_d  = warm_q - 1'b1;
                    state_d = S_FIRE;
                end else if (drawn_q == num_q) begin
                    // only reachable with num_cards == 0
                    state_d = S_FINISH;
                end else if ((cand_idx >= DECK_LIM) || mask_hit) begin
                    rej_d = rej_q + 1'b1;
                    if (rej_q == REJ_W'(MAX_REJECT - 1)) begin
                        err_stall_d = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_FIRE;
                    end
                end else begin
                    card_valid = 1'b1;
                    mask_set   = 1'b1;
                    rej_d      = '0;
                    drawn_d    = drawn_q + 1'b1;
                    state_d    = (drawn_d == num_q) ? S_FINISH : S_FIRE;
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            map_x_q       <= '0;
            map_y_q       <= '0;
            map_a_q       <= '0;
            map_b_q       <= '0;
            map_perturb_q <= '0;
            warm_q        <= '0;
            tmo_q         <= '0;
            rej_q         <= '0;
            num_q         <= '0;
            drawn_q       <= '0;
            err_timeout_q <= 1'b0;
            err_stall_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            map_x_q       <= map_x_d;
            map_y_q       <= map_y_d;
            map_a_q       <= map_a_d;
            map_b_q       <= map_b_d;
            map_perturb_q <= map_perturb_d;
            warm_q        <= warm_d;
            tmo_q         <= tmo_d;
            rej_q         <= rej_d;
            num_q         <= num_d;
            drawn_q       <= drawn_d;
            err_timeout_q <= err_timeout_d;
            err_stall_q   <= err_stall_d;
        end
    end

    assign map_start   = (state_q == S_FIRE);
    assign draw_done   = (state_q == S_FINISH);
    assign busy        = (state_q == S_FIRE) || (state_q == S_WAIT) || (state_q == S_EVAL);
    assign card_idx    = card_valid ? cand_idx : '0;
    assign card_rev    = card_valid & cand_rev;
    assign map_x       = map_x_q;
    assign map_y       = map_y_q;
    assign map_a       = map_a_q;
    assign map_b       = map_b_q;
    assign map_perturb = map_perturb_q;
    assign err_timeout = err_timeout_q;
    assign err_stall   = err_stall_q;

endmodule
